// File: rtl/simple_fetch_unit.sv
// rtl/simple_fetch_unit.sv - instruction fetch with prefetch FIFO and branch redirect
module simple_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [DATA_W-1:0] NOP_INS  = 32'h00000001
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_en,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [DATA_W-1:0]        cur_ins,
   output logic [ADDR_W-1:0]        ins_pc,
   output logic                     ins_valid,
   input  logic                     ins_ready,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pc_q;
   logic              inflight;

   logic [DATA_W-1:0] ins_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem  [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   cnt_t              count;

   cnt_t              credits;
   logic              not_empty;
   logic              push;
   logic              pop;

   // credits = FIFO slots already promised: stored words plus the read in flight
   always_comb begin
      credits   = count + cnt_t'(inflight);
      not_empty = (count != '0);
   end

   // issue a read only when its response is guaranteed a slot; a redirect flushes everything
   always_comb begin
      mem_en   = rst & ~redirect & (credits < DEPTH_C);
      mem_addr = fetch_pc;
      push     = inflight & ~redirect;
      pop      = not_empty & ins_ready & ~redirect;
   end

   // present the FIFO head, or a NOP while nothing is buffered
   always_comb begin
      ins_valid  = not_empty;
      fifo_count = count;
      cur_ins    = NOP_INS;
      ins_pc     = '0;
      if (not_empty) begin
         cur_ins = ins_mem[rd_ptr];
         ins_pc  = pc_mem[rd_ptr];
      end
   end

   // fetch pointer and the single outstanding read; redirect restarts fetch without issuing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         inflight <= 1'b0;
         pc_q     <= '0;
      end else begin
         if (redirect) begin
            fetch_pc <= redirect_pc;
         end else if (mem_en) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
         end
         inflight <= mem_en;
         if (mem_en) begin
            pc_q <= fetch_pc;
         end
      end
   end

   // FIFO pointers and occupancy; flush on redirect wins over any push or pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; the word returned by memory is paired with the address that fetched it
   always_ff @(posedge clk) begin
      if (push) begin
         ins_mem[wr_ptr] <= mem_rdata;
         pc_mem[wr_ptr]  <= pc_q;
      end
   end

endmodule

// File: tb/tb_simple_fetch_unit.sv
// tb/tb_simple_fetch_unit.sv - self-checking bench for simple_fetch_unit
`timescale 1ns/1ps
module tb_simple_fetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000001;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        mem_en, mem_en2;
   logic [7:0]  mem_addr, mem_addr2;
   logic [31:0] mem_rdata = '0, mem_rdata2 = '0;
   logic [31:0] cur_ins, cur_ins2;
   logic [7:0]  ins_pc, ins_pc2;
   logic        ins_valid, ins_valid2;
   logic        ins_ready = 1'b0, ready2 = 1'b1;
   logic        redirect = 1'b0, redirect2 = 1'b0;
   logic [7:0]  redirect_pc = '0, redirect_pc2 = '0;
   logic [2:0]  fifo_count, fifo_count2;

   logic [31:0] mem_img [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   simple_fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(8'h00), .NOP_INS(NOP)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .cur_ins(cur_ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count));

   simple_fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(8'hFE), .NOP_INS(NOP)) dut_wrap (
      .clk(clk), .rst(rst), .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
      .cur_ins(cur_ins2), .ins_pc(ins_pc2), .ins_valid(ins_valid2), .ins_ready(ready2),
      .redirect(redirect2), .redirect_pc(redirect_pc2), .fifo_count(fifo_count2));

   // synchronous instruction memories, one-cycle read latency
   always @(posedge clk) if (mem_en)  mem_rdata  <= mem_img[mem_addr];
   always @(posedge clk) if (mem_en2) mem_rdata2 <= mem_img[mem_addr2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rdy;
      logic       redir;
      logic [7:0] rpc;
      logic       valid;
      logic [7:0] pc;
      logic [2:0] cnt;
      logic       en;
   } vec_t;

   vec_t vt[$];

   task automatic add_vec(input logic rdy, input logic redir, input logic [7:0] rpc,
                          input logic v, input logic [7:0] pc, input logic [2:0] cnt, input logic en);
      vec_t r;
      r.rdy = rdy; r.redir = redir; r.rpc = rpc;
      r.valid = v; r.pc = pc; r.cnt = cnt; r.en = en;
      vt.push_back(r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      ins_ready = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // reference model: a queue of buffered fetch addresses plus the accepted-stream expectation
   int mq[$];
   bit m_infl;
   int m_infl_pc;
   int m_fpc;
   int exp_next;

   task automatic model_edge();
      bit en;
      en = !redirect && (mq.size() + int'(m_infl) < DEPTH);
      if (redirect) begin
         mq.delete();
         m_infl   = 1'b0;
         m_fpc    = int'(redirect_pc);
         exp_next = int'(redirect_pc);
      end else begin
         if (mq.size() > 0 && ins_ready) begin
            void'(mq.pop_front());
            exp_next = (exp_next + 1) % 256;
         end
         if (m_infl) mq.push_back(m_infl_pc);
         m_infl = en;
         if (en) begin
            m_infl_pc = m_fpc;
            m_fpc     = (m_fpc + 1) % 256;
         end
      end
   endtask

   task automatic model_check();
      check("rnd_count", fifo_count, mq.size());
      check("rnd_valid", ins_valid, mq.size() != 0);
      check("rnd_mem_en", mem_en, !redirect && (mq.size() + int'(m_infl) < DEPTH));
      check("rnd_mem_addr", mem_addr, m_fpc);
      if (mq.size() != 0) begin
         check("rnd_ins_pc", ins_pc, mq[0]);
         check("rnd_cur_ins", cur_ins, mem_img[mq[0]]);
      end else begin
         check("rnd_ins_pc_empty", ins_pc, 0);
         check("rnd_cur_ins_nop", cur_ins, NOP);
      end
   endtask

   initial begin
      logic [31:0] exp_ins;
      logic [7:0]  p2;

      for (int i = 0; i < 256; i++) mem_img[i] = i + 100;

      // startup backpressure, release, then redirect to 0x40
      add_vec(0, 0, 8'h00, 0, 8'h00, 3'd0, 1);
      add_vec(0, 0, 8'h00, 1, 8'h00, 3'd1, 1);
      add_vec(0, 0, 8'h00, 1, 8'h00, 3'd2, 1);
      add_vec(0, 0, 8'h00, 1, 8'h00, 3'd3, 0);
      for (int i = 0; i < 6; i++) add_vec(0, 0, 8'h00, 1, 8'h00, 3'd4, 0);
      add_vec(1, 0, 8'h00, 1, 8'h01, 3'd3, 1);
      add_vec(1, 0, 8'h00, 1, 8'h02, 3'd2, 1);
      add_vec(1, 0, 8'h00, 1, 8'h03, 3'd2, 1);
      add_vec(1, 0, 8'h00, 1, 8'h04, 3'd2, 1);
      add_vec(1, 0, 8'h00, 1, 8'h05, 3'd2, 1);
      add_vec(1, 1, 8'h40, 0, 8'h00, 3'd0, 0);
      add_vec(1, 0, 8'h00, 0, 8'h00, 3'd0, 1);
      add_vec(1, 0, 8'h00, 1, 8'h40, 3'd1, 1);
      add_vec(1, 0, 8'h00, 1, 8'h41, 3'd1, 1);

      repeat (2) @(negedge clk);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_valid", ins_valid, 1'b0);
      check("rst_cur_ins", cur_ins, NOP);
      check("rst_ins_pc", ins_pc, 8'h00);
      check("rst_count", fifo_count, 3'd0);
      check("rst_mem_addr", mem_addr, 8'h00);
      rst = 1'b1;

      for (int k = 0; k < vt.size(); k++) begin
         ins_ready   = vt[k].rdy;
         redirect    = vt[k].redir;
         redirect_pc = vt[k].rpc;
         step();
         exp_ins = vt[k].valid ? (32'(vt[k].pc) + 32'd100) : NOP;
         check($sformatf("vec%0d_valid", k), ins_valid, vt[k].valid);
         check($sformatf("vec%0d_ins_pc", k), ins_pc, vt[k].pc);
         check($sformatf("vec%0d_cur_ins", k), cur_ins, exp_ins);
         check($sformatf("vec%0d_count", k), fifo_count, vt[k].cnt);
         check($sformatf("vec%0d_mem_en", k), mem_en, vt[k].en);
         if (k == 0) begin
            check("wrap_valid0", ins_valid2, 1'b0);
         end else if (k <= 4) begin
            p2 = 8'hFE + 8'(k - 1);
            check($sformatf("wrap%0d_ins_pc", k), ins_pc2, p2);
            check($sformatf("wrap%0d_cur_ins", k), cur_ins2, mem_img[p2]);
         end
      end
      redirect = 1'b0;

      // reset asserted mid-stream takes effect without a clock edge
      #2;
      rst = 1'b0;
      #1;
      check("midrst_mem_en", mem_en, 1'b0);
      check("midrst_valid", ins_valid, 1'b0);
      check("midrst_cur_ins", cur_ins, NOP);
      check("midrst_ins_pc", ins_pc, 8'h00);
      check("midrst_count", fifo_count, 3'd0);
      @(negedge clk);
      check("midrst_hold_valid", ins_valid, 1'b0);
      check("midrst_hold_mem_en", mem_en, 1'b0);

      // redirect with a pop requested and a push pending into a nearly full FIFO
      do_reset();
      repeat (4) step();
      check("sim_fill_count", fifo_count, 3'd3);
      check("sim_fill_mem_en", mem_en, 1'b0);
      ins_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 8'h80;
      step();
      check("sim_flush_count", fifo_count, 3'd0);
      check("sim_flush_valid", ins_valid, 1'b0);
      check("sim_flush_mem_en", mem_en, 1'b0);
      redirect = 1'b0;
      step();
      check("sim_issue_count", fifo_count, 3'd0);
      check("sim_issue_mem_en", mem_en, 1'b1);
      check("sim_issue_addr", mem_addr, 8'h81);
      step();
      check("sim_first_valid", ins_valid, 1'b1);
      check("sim_first_pc", ins_pc, 8'h80);
      check("sim_first_ins", cur_ins, mem_img[8'h80]);

      // randomized ready/redirect run against the queue model
      for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
      do_reset();
      mq.delete();
      m_infl    = 1'b0;
      m_infl_pc = 0;
      m_fpc     = 0;
      exp_next  = 0;
      for (int c = 0; c < 3000; c++) begin
         ins_ready   = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = 8'($urandom);
         if (((c / 200) % 2 == 1) && (c % 200 < 15)) begin
            ins_ready = 1'b0;
            redirect  = 1'b0;
         end
         if (ins_valid && ins_ready && !redirect) begin
            check("stream_pc", ins_pc, exp_next);
            check("stream_ins", cur_ins, mem_img[exp_next]);
         end
         @(posedge clk);
         model_edge();
         @(negedge clk);
         model_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
